imem_ctrl: RTL and testbench

Controller sequencing the single-port 64x32 instruction memory between two requesters: CPU instruction fetch (read) and a program loader (write).
- Replaces simulation-time file reloads with a hardware load sequence: stall CPU, optionally zero the array, accept loader writes, release CPU.
- Sits between the fetch stage and the memory array and drives the array's address and write controls.

---
 rtl/imem_ctrl_pkg.sv | 20 ++
 rtl/imem_ctrl_if.sv | 36 +++
 rtl/imem_run_arb.sv | 42 ++++
 rtl/imem_ctrl.sv | 129 ++++++++++++
 tb/tb_imem_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_ctrl_pkg.sv
// Shared types for the instruction-memory controller: FSM states, grant select
// and the default loader starvation limit.
package imem_ctrl_pkg;

   localparam int STARVE_MAX_DEF = 4;

   typedef enum logic [1:0] {
      RUN  = 2'd0,
      ZERO = 2'd1,
      LOAD = 2'd2
   } imem_state_e;

   typedef enum logic [1:0] {
      GNT_NONE  = 2'd0,
      GNT_FETCH = 2'd1,
      GNT_LOAD  = 2'd2,
      GNT_ZERO  = 2'd3
   } gnt_sel_e;

endpackage

// File: rtl/imem_ctrl_if.sv
// Fetch, loader and array-side signals of imem_ctrl. The slave modport is the
// controller's view; master is the requesters' and array's view.
interface imem_ctrl_if #(
   parameter int AW = 6,
   parameter int DW = 32
);
   logic          f_req;
   logic [AW-1:0] f_addr;
   logic          f_gnt;
   logic          f_rvalid;
   logic [DW-1:0] f_rdata;
   logic          l_start;
   logic          l_req;
   logic [AW-1:0] l_addr;
   logic [DW-1:0] l_wdata;
   logic          l_done;
   logic          l_gnt;
   logic          l_busy;
   logic          cpu_stall;
   logic [AW-1:0] mem_a;
   logic          mem_we;
   logic [DW-1:0] mem_wd;
   logic [DW-1:0] mem_rd;

   modport slave (
      input  f_req, f_addr, l_start, l_req, l_addr, l_wdata, l_done, mem_rd,
      output f_gnt, f_rvalid, f_rdata, l_gnt, l_busy, cpu_stall,
             mem_a, mem_we, mem_wd
   );

   modport master (
      output f_req, f_addr, l_start, l_req, l_addr, l_wdata, l_done, mem_rd,
      input  f_gnt, f_rvalid, f_rdata, l_gnt, l_busy, cpu_stall,
             mem_a, mem_we, mem_wd
   );
endinterface

// File: rtl/imem_run_arb.sv
// RUN-state arbiter: fetch has priority, but a loader denied STARVE_MAX
// consecutive cycles wins the next one.
module imem_run_arb
   import imem_ctrl_pkg::*;
#(
   parameter int STARVE_MAX = STARVE_MAX_DEF
) (
   input  logic     clk,
   input  logic     reset_n,
   input  logic     en,
   input  logic     f_req,
   input  logic     l_req,
   output gnt_sel_e gnt_sel
);

   localparam logic [3:0] STARVE_TC = 4'(STARVE_MAX);

   logic [3:0] starve_cnt;

   always_comb begin
      gnt_sel = GNT_NONE;
      if (en) begin
         if (l_req && (!f_req || starve_cnt == STARVE_TC)) begin
            gnt_sel = GNT_LOAD;
         end else if (f_req) begin
            gnt_sel = GNT_FETCH;
         end
      end
   end

   // outside RUN the loader is either served or parked, so history restarts
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         starve_cnt <= 4'd0;
      end else if (!en || !l_req || gnt_sel == GNT_LOAD) begin
         starve_cnt <= 4'd0;
      end else if (starve_cnt != STARVE_TC) begin
         starve_cnt <= starve_cnt + 4'd1;
      end
   end

endmodule

// File: rtl/imem_ctrl.sv
// Instruction-memory controller: fetch/loader arbitration and the program load
// sequence. Define IMEM_ZERO_FILL_EN to clear the whole array before each load.
//
// state | meaning
// RUN   | CPU fetching, loader writes arbitrated in
// ZERO  | array being cleared one word per cycle (IMEM_ZERO_FILL_EN only)
// LOAD  | CPU stalled, loader owns the array until l_done
module imem_ctrl
   import imem_ctrl_pkg::*;
#(
   parameter int AW         = 6,
   parameter int DW         = 32,
   parameter int STARVE_MAX = STARVE_MAX_DEF
) (
   input logic        clk,
   input logic        reset_n,
   imem_ctrl_if.slave bus
);

   imem_state_e   state;
   gnt_sel_e      arb_sel;
   gnt_sel_e      sel;
   logic          busy;
   logic          rvalid;
   logic [DW-1:0] rdata;
`ifdef IMEM_ZERO_FILL_EN
   logic [AW-1:0] zero_ptr;
`endif

   imem_run_arb #(
      .STARVE_MAX (STARVE_MAX)
   ) u_run_arb (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (state == RUN),
      .f_req   (bus.f_req),
      .l_req   (bus.l_req),
      .gnt_sel (arb_sel)
   );

   always_comb begin
      sel = GNT_NONE;
      case (state)
         RUN:     sel = arb_sel;
`ifdef IMEM_ZERO_FILL_EN
         ZERO:    sel = GNT_ZERO;
`endif
         LOAD:    sel = bus.l_req ? GNT_LOAD : GNT_NONE;
         default: sel = GNT_NONE;
      endcase
   end

   assign bus.f_gnt     = (sel == GNT_FETCH);
   assign bus.l_gnt     = (sel == GNT_LOAD);
   assign bus.f_rvalid  = rvalid;
   assign bus.f_rdata   = rdata;
   assign bus.l_busy    = busy;
   assign bus.cpu_stall = busy;

   always_comb begin
      bus.mem_a  = '0;
      bus.mem_we = 1'b0;
      bus.mem_wd = '0;
      case (sel)
         GNT_FETCH: bus.mem_a = bus.f_addr;
         GNT_LOAD: begin
            bus.mem_a  = bus.l_addr;
            bus.mem_we = 1'b1;
            bus.mem_wd = bus.l_wdata;
         end
`ifdef IMEM_ZERO_FILL_EN
         GNT_ZERO: begin
            bus.mem_a  = zero_ptr;
            bus.mem_we = 1'b1;
         end
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= RUN;
         busy   <= 1'b0;
         rvalid <= 1'b0;
         rdata  <= '0;
`ifdef IMEM_ZERO_FILL_EN
         zero_ptr <= '0;
`endif
      end else begin
         rvalid <= bus.f_gnt;
         if (bus.f_gnt) begin
            rdata <= bus.mem_rd;
         end
         case (state)
            RUN: begin
               if (bus.l_start) begin
`ifdef IMEM_ZERO_FILL_EN
                  state <= ZERO;
`else
                  state <= LOAD;
`endif
                  busy <= 1'b1;
               end
            end
`ifdef IMEM_ZERO_FILL_EN
            ZERO: begin
               // pointer wraps to 0 on the last word, ready for the next load
               zero_ptr <= zero_ptr + AW'(1);
               if (zero_ptr == {AW{1'b1}}) begin
                  state <= LOAD;
               end
            end
`endif
            LOAD: begin
               if (bus.l_done) begin
                  state <= RUN;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= RUN;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_imem_ctrl.sv
// Self-checking bench for imem_ctrl: vector table for arbitration, random RUN
// traffic against a reference model, and hand sequences for load and reset.
module tb_imem_ctrl;

   localparam int AW    = 6;
   localparam int DW    = 32;
   localparam int SMAX  = 4;
   localparam int DEPTH = 64;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   imem_ctrl_if #(.AW(AW), .DW(DW)) bus ();

   imem_ctrl #(
      .AW         (AW),
      .DW         (DW),
      .STARVE_MAX (SMAX)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   // physical array plus a backdoor port used only to preload it
   logic [DW-1:0] mem_arr [DEPTH];
   logic          bk_we;
   logic [AW-1:0] bk_a;
   logic [DW-1:0] bk_d;

   always @(posedge clk) begin
      if (bk_we) mem_arr[bk_a] <= bk_d;
      else if (bus.mem_we) mem_arr[bus.mem_a] <= bus.mem_wd;
   end
   assign bus.mem_rd = mem_arr[bus.mem_a];

   logic [DW-1:0] ref_mem [DEPTH];
   logic [DW-1:0] exp_last;
   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic          fr;
      logic          lr;
      logic [AW-1:0] fa;
      logic [AW-1:0] la;
      logic [DW-1:0] wd;
      logic          efg;
      logic          elg;
   } vec_t;

   vec_t vt [23];

   function automatic vec_t mk(input int fr, input int lr, input int fa,
                               input int la, input int efg, input int elg);
      vec_t v;
      v.fr  = (fr != 0);
      v.lr  = (lr != 0);
      v.fa  = AW'(fa);
      v.la  = AW'(la);
      v.wd  = 32'hA000_0000 | 32'(la);
      v.efg = (efg != 0);
      v.elg = (elg != 0);
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      bus.f_req   = 1'b0;
      bus.f_addr  = '0;
      bus.l_start = 1'b0;
      bus.l_req   = 1'b0;
      bus.l_addr  = '0;
      bus.l_wdata = '0;
      bus.l_done  = 1'b0;
   endtask

   task automatic preload();
      bk_we = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         bk_a       = AW'(i);
         bk_d       = $urandom | 32'h1;
         ref_mem[i] = bk_d;
         tick();
      end
      bk_we = 1'b0;
   endtask

   task automatic read_check(input int a, input string name);
      bus.f_req  = 1'b1;
      bus.f_addr = AW'(a);
      #1;
      chk({name, "_fgnt"}, 32'(bus.f_gnt), 32'd1);
      chk({name, "_mema"}, 32'(bus.mem_a), 32'(a));
      exp_last = ref_mem[a];
      tick();
      chk({name, "_rvalid"}, 32'(bus.f_rvalid), 32'd1);
      chk({name, "_rdata"}, bus.f_rdata, exp_last);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic fr, lr, dn, lw, fw;
      logic [AW-1:0] fa, la;
      logic [DW-1:0] ld;
      int starve;
      int rd_list [5];

      vt[0]  = mk(1, 1, 1, 40, 1, 0);
      vt[1]  = mk(1, 1, 2, 41, 1, 0);
      vt[2]  = mk(1, 1, 3, 42, 1, 0);
      vt[3]  = mk(1, 1, 4, 43, 1, 0);
      vt[4]  = mk(1, 1, 5, 44, 0, 1);
      vt[5]  = mk(1, 1, 6, 45, 1, 0);
      vt[6]  = mk(1, 1, 7, 45, 1, 0);
      vt[7]  = mk(1, 1, 8, 45, 1, 0);
      vt[8]  = mk(1, 1, 9, 45, 1, 0);
      vt[9]  = mk(1, 1, 10, 45, 0, 1);
      vt[10] = mk(1, 0, 11, 46, 1, 0);
      vt[11] = mk(1, 1, 12, 46, 1, 0);
      vt[12] = mk(0, 1, 13, 46, 0, 1);
      vt[13] = mk(0, 0, 14, 47, 0, 0);
      vt[14] = mk(1, 1, 15, 47, 1, 0);
      vt[15] = mk(1, 1, 16, 47, 1, 0);
      vt[16] = mk(1, 0, 17, 47, 1, 0);
      vt[17] = mk(1, 1, 18, 47, 1, 0);
      vt[18] = mk(1, 1, 19, 47, 1, 0);
      vt[19] = mk(1, 1, 20, 47, 1, 0);
      vt[20] = mk(1, 1, 21, 47, 1, 0);
      vt[21] = mk(1, 1, 22, 47, 0, 1);
      vt[22] = mk(0, 0, 23, 47, 0, 0);
      rd_list = '{0, 3, 10, 63, 7};

      // reset held with a fetch request pending
      idle_in();
      bk_we = 1'b0;
      bk_a  = '0;
      bk_d  = '0;
      reset_n = 1'b0;
      bus.f_req  = 1'b1;
      bus.f_addr = AW'(5);
      preload();
      chk("rst_rvalid", 32'(bus.f_rvalid), 32'd0);
      chk("rst_stall", 32'(bus.cpu_stall), 32'd0);
      chk("rst_busy", 32'(bus.l_busy), 32'd0);
      chk("rst_rdata", bus.f_rdata, 32'd0);

      reset_n = 1'b1;
      read_check(5, "rd5");

      // arbitration table
      for (int i = 0; i < 23; i++) begin
         bus.f_req   = vt[i].fr;
         bus.l_req   = vt[i].lr;
         bus.f_addr  = vt[i].fa;
         bus.l_addr  = vt[i].la;
         bus.l_wdata = vt[i].wd;
         #1;
         chk($sformatf("vec%0d_fgnt", i), 32'(bus.f_gnt), 32'(vt[i].efg));
         chk($sformatf("vec%0d_lgnt", i), 32'(bus.l_gnt), 32'(vt[i].elg));
         chk($sformatf("vec%0d_we", i), 32'(bus.mem_we), 32'(vt[i].elg));
         chk($sformatf("vec%0d_mema", i), 32'(bus.mem_a),
             vt[i].efg ? 32'(vt[i].fa) : vt[i].elg ? 32'(vt[i].la) : 32'd0);
         chk($sformatf("vec%0d_memwd", i), bus.mem_wd, vt[i].elg ? vt[i].wd : 32'd0);
         if (vt[i].efg) exp_last = ref_mem[vt[i].fa];
         if (vt[i].elg) ref_mem[vt[i].la] = vt[i].wd;
         tick();
         chk($sformatf("vec%0d_rvalid", i), 32'(bus.f_rvalid), 32'(vt[i].efg));
         chk($sformatf("vec%0d_rdata", i), bus.f_rdata, exp_last);
      end
      idle_in();

      // random RUN traffic against the reference model; l_done must be ignored
      starve = 0;
      for (int n = 0; n < 400; n++) begin
         fr = ($urandom_range(0, 3) != 0);
         lr = ($urandom_range(0, 3) != 0);
         dn = ($urandom_range(0, 7) == 0);
         fa = AW'($urandom);
         la = AW'($urandom);
         ld = $urandom;
         bus.f_req = fr; bus.l_req = lr; bus.f_addr = fa;
         bus.l_addr = la; bus.l_wdata = ld; bus.l_done = dn;
         #1;
         lw = lr && (!fr || starve >= SMAX);
         fw = fr && !lw;
         chk("rnd_fgnt", 32'(bus.f_gnt), 32'(fw));
         chk("rnd_lgnt", 32'(bus.l_gnt), 32'(lw));
         chk("rnd_we", 32'(bus.mem_we), 32'(lw));
         chk("rnd_mema", 32'(bus.mem_a), fw ? 32'(fa) : lw ? 32'(la) : 32'd0);
         chk("rnd_memwd", bus.mem_wd, lw ? ld : 32'd0);
         if (fw) exp_last = ref_mem[fa];
         if (lw) ref_mem[la] = ld;
         starve = (lr && !lw) ? ((starve + 1 > SMAX) ? SMAX : starve + 1) : 0;
         tick();
         chk("rnd_rvalid", 32'(bus.f_rvalid), 32'(fw));
         chk("rnd_rdata", bus.f_rdata, exp_last);
         chk("rnd_stall", 32'(bus.cpu_stall), 32'd0);
      end
      idle_in();
      tick();

      // load sequence: fetch still honoured in the l_start cycle
      bus.f_req   = 1'b1;
      bus.f_addr  = AW'(7);
      bus.l_start = 1'b1;
      #1;
      chk("ls_fgnt", 32'(bus.f_gnt), 32'd1);
      chk("ls_stall0", 32'(bus.cpu_stall), 32'd0);
      exp_last = ref_mem[7];
      tick();
      bus.l_start = 1'b0;
      chk("ls_stall1", 32'(bus.cpu_stall), 32'd1);
      chk("ls_busy1", 32'(bus.l_busy), 32'd1);
      chk("ls_rvalid", 32'(bus.f_rvalid), 32'd1);
      chk("ls_rdata", bus.f_rdata, exp_last);

`ifdef IMEM_ZERO_FILL_EN
      bus.l_req  = 1'b1;
      bus.l_addr = AW'(9);
      for (int i = 0; i < DEPTH; i++) begin
         #1;
         chk($sformatf("zero%0d_we", i), 32'(bus.mem_we), 32'd1);
         chk($sformatf("zero%0d_a", i), 32'(bus.mem_a), 32'(i));
         chk($sformatf("zero%0d_wd", i), bus.mem_wd, 32'd0);
         chk($sformatf("zero%0d_gnt", i), 32'({bus.f_gnt, bus.l_gnt}), 32'd0);
         ref_mem[i] = '0;
         tick();
      end
`endif

      bus.f_req   = 1'b1;
      bus.l_req   = 1'b1;
      bus.l_addr  = AW'(3);
      bus.l_wdata = 32'h1234_5678;
      #1;
      chk("ld_fgnt", 32'(bus.f_gnt), 32'd0);
      chk("ld_lgnt", 32'(bus.l_gnt), 32'd1);
      chk("ld_we", 32'(bus.mem_we), 32'd1);
      chk("ld_mema", 32'(bus.mem_a), 32'd3);
      chk("ld_memwd", bus.mem_wd, 32'h1234_5678);
      ref_mem[3] = 32'h1234_5678;
      tick();
      chk("ld_stall", 32'(bus.cpu_stall), 32'd1);
      chk("ld_rvalid", 32'(bus.f_rvalid), 32'd0);

      bus.l_req   = 1'b0;
      bus.l_start = 1'b1;
      #1;
      chk("ldst_fgnt", 32'(bus.f_gnt), 32'd0);
      chk("ldst_we", 32'(bus.mem_we), 32'd0);
      tick();
      bus.l_start = 1'b0;
      #1;
      chk("ldst_stall", 32'(bus.cpu_stall), 32'd1);
      chk("ldst_we2", 32'(bus.mem_we), 32'd0);
      chk("ldst_fgnt2", 32'(bus.f_gnt), 32'd0);
      tick();

      bus.l_req   = 1'b1;
      bus.l_addr  = AW'(0);
      bus.l_wdata = 32'h2008_0005;
      bus.l_done  = 1'b1;
      #1;
      chk("done_lgnt", 32'(bus.l_gnt), 32'd1);
      chk("done_fgnt", 32'(bus.f_gnt), 32'd0);
      chk("done_mema", 32'(bus.mem_a), 32'd0);
      chk("done_memwd", bus.mem_wd, 32'h2008_0005);
      ref_mem[0] = 32'h2008_0005;
      tick();
      bus.l_done = 1'b0;
      bus.l_req  = 1'b0;
      chk("done_stall", 32'(bus.cpu_stall), 32'd0);
      chk("done_busy", 32'(bus.l_busy), 32'd0);

      for (int i = 0; i < 5; i++) begin
         read_check(rd_list[i], $sformatf("post%0d", rd_list[i]));
      end
      idle_in();
      tick();

      // reset during the load sequence
      preload();
      bus.l_start = 1'b1;
      tick();
      bus.l_start = 1'b0;
`ifdef IMEM_ZERO_FILL_EN
      for (int k = 0; k < 30; k++) begin
         ref_mem[k] = '0;
         tick();
      end
      #1;
      chk("rz_mema30", 32'(bus.mem_a), 32'd30);
      chk("rz_we30", 32'(bus.mem_we), 32'd1);
`endif
      reset_n = 1'b0;
      #1;
      chk("rz_stall", 32'(bus.cpu_stall), 32'd0);
      chk("rz_busy", 32'(bus.l_busy), 32'd0);
      chk("rz_we", 32'(bus.mem_we), 32'd0);
      tick();
      reset_n = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         read_check(i, $sformatf("rz_rd%0d", i));
      end
      idle_in();
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
